// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: owner encoding, widths and hold-counter sizing shared by the RAM port arbiter
package ram_arb_pkg;
  localparam int DATA_W = 32;
  localparam int MAX_HOLD_DEF = 8;
  localparam int HOLD_W_DEF = $clog2(MAX_HOLD_DEF + 1);
  typedef enum logic [1:0] {OWN_M0 = 2'd0, OWN_M1 = 2'd1, OWN_NONE = 2'd2} own_e;
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: 2-way round-robin pick; on a tie the master that did not win last time wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master round-robin arbiter for a single-port byte-write RAM,
// with optional locked ownership bounded by MAX_HOLD and registered per-master read data
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [3:0]            m0_we,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [3:0]            m1_we,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_W-1:0]     ram_d,
  output logic [3:0]            ram_we,
  input  logic [DATA_W-1:0]     ram_spo
);
  localparam int HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  own_e own_q, own_d, sel_own;
  logic [HW-1:0] hold_q, hold_d;
  logic last_q, last_d;
  logic [1:0] rvalid_q, rvalid_d, rr_gnt, gnt;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic lock0, lock1, sel, any, rd, lock_sel, other_req;
  rr_pick2 u_rr (.req({m1_req, m0_req}), .last(last_q), .gnt(rr_gnt));
  // a locked owner keeps the port until the other master has waited MAX_HOLD grants
  always_comb begin
    lock0 = own_q == OWN_M0 && m0_req && (!m1_req || hold_q < HOLD_MAX);
    lock1 = own_q == OWN_M1 && m1_req && (!m0_req || hold_q < HOLD_MAX);
    gnt = rst ? 2'b00 : lock0 ? 2'b01 : lock1 ? 2'b10 : rr_gnt;
    sel = gnt[1];
    any = |gnt;
    sel_own = sel ? OWN_M1 : OWN_M0;
    lock_sel = sel ? m1_lock : m0_lock;
    other_req = sel ? m0_req : m1_req;
    ram_a = gnt[1] ? m1_addr : gnt[0] ? m0_addr : '0;
    ram_d = gnt[1] ? m1_wdata : gnt[0] ? m0_wdata : '0;
    ram_we = gnt[1] ? m1_we : gnt[0] ? m0_we : '0;
    rd = any && m0_we == 4'b0 && !sel || any && m1_we == 4'b0 && sel;
    last_d = any ? sel : last_q;
    own_d = any && lock_sel ? sel_own : OWN_NONE;
    hold_d = any && lock_sel && own_q == sel_own && other_req ?
             (hold_q == HOLD_MAX ? HOLD_MAX : hold_q + 1'b1) : '0;
    rvalid_d = gnt & {2{rd}};
    rdata0_d = gnt[0] && rd ? ram_spo : rdata0_q;
    rdata1_d = gnt[1] && rd ? ram_spo : rdata1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q <= OWN_NONE;
      hold_q <= '0;
      last_q <= 1'b1;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      own_q <= own_d;
      hold_q <= hold_d;
      last_q <= last_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus random traffic checked against a
// rule-level reference model of grants, locking, RAM contents and read responses
module tb_ram_port_arbiter;
  localparam int AW = 14;
  localparam int MH = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_a[2], lock_a[2];
  logic [AW-1:0] addr_a[2];
  logic [31:0] wd_a[2];
  logic [3:0] we_a[2];
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, ram_d, ram_spo;
  logic [AW-1:0] ram_a;
  logic [3:0] ram_we;
  logic [31:0] mem [1<<AW];
  logic [31:0] ref_mem [1<<AW];
  int checks = 0;
  int fails = 0;
  int own, hold, last_id, gprev;
  logic ev[2];
  logic [31:0] er[2];
  logic [1:0] dq[$];
  always #5 clk = ~clk;
  ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req_a[0]), .m0_lock(lock_a[0]), .m0_addr(addr_a[0]), .m0_wdata(wd_a[0]),
    .m0_we(we_a[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req_a[1]), .m1_lock(lock_a[1]), .m1_addr(addr_a[1]), .m1_wdata(wd_a[1]),
    .m1_we(we_a[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
  );
  assign ram_spo = mem[ram_a];
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
  function automatic logic [31:0] pre(input int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic setm(input int i, input logic r, input logic l, input int a,
                      input logic [31:0] d, input logic [3:0] w);
    req_a[i] = r;
    lock_a[i] = l;
    addr_a[i] = a[AW-1:0];
    wd_a[i] = d;
    we_a[i] = w;
  endtask
  task automatic model_reset();
    own = -1;
    hold = 0;
    last_id = 1;
    gprev = -1;
    ev = '{1'b0, 1'b0};
    er = '{32'h0, 32'h0};
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt", {m1_gnt, m0_gnt}, 32'h0);
    chk("rst_we", ram_we, 32'h0);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, {ev[1], ev[0]});
    chk("rst_rdata0", m0_rdata, er[0]);
    chk("rst_rdata1", m1_rdata, er[1]);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  // one cycle: check combinational grant/RAM drive and registered responses, then advance model
  task automatic step();
    int g, gi, o;
    logic [1:0] gv;
    @(negedge clk);
    if (own >= 0 && req_a[own] && (!req_a[1-own] || hold < MH)) g = own;
    else if (req_a[0] && req_a[1]) g = 1 - last_id;
    else if (req_a[0]) g = 0;
    else if (req_a[1]) g = 1;
    else g = -1;
    gi = g < 0 ? 0 : g;
    gv = g < 0 ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
    dq.push_back({m1_gnt, m0_gnt});
    chk("gnt", {m1_gnt, m0_gnt}, gv);
    chk("ram_we", ram_we, g < 0 ? 4'h0 : we_a[gi]);
    chk("ram_a", ram_a, g < 0 ? '0 : addr_a[gi]);
    chk("ram_d", ram_d, g < 0 ? 32'h0 : wd_a[gi]);
    chk("rvalid0", m0_rvalid, ev[0]);
    chk("rvalid1", m1_rvalid, ev[1]);
    chk("rdata0", m0_rdata, er[0]);
    chk("rdata1", m1_rdata, er[1]);
    if (g >= 0) begin
      o = 1 - g;
      ev[o] = 1'b0;
      if (we_a[g] == 4'h0) begin
        ev[g] = 1'b1;
        er[g] = ref_mem[addr_a[g]];
      end else begin
        ev[g] = 1'b0;
        for (int b = 0; b < 4; b++)
          if (we_a[g][b]) ref_mem[addr_a[g]][8*b +: 8] = wd_a[g][8*b +: 8];
      end
      if (lock_a[g]) begin
        hold = (own == g && req_a[o]) ? (hold + 1 > MH ? MH : hold + 1) : 0;
        own = g;
      end else begin
        own = -1;
        hold = 0;
      end
      last_id = g;
    end else begin
      ev = '{1'b0, 1'b0};
      own = -1;
      hold = 0;
    end
    gprev = g;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int s;
    logic [31:0] p;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = pre(i);
      ref_mem[i] = pre(i);
    end
    setm(0, 1, 0, 1, 32'h0, 4'h0);
    setm(1, 1, 0, 2, 32'h0, 4'h0);
    #1;
    do_reset();
    // both read after reset: m0 first, then m1
    s = dq.size();
    step();
    step();
    chk("t1_first", dq[s], 32'h1);
    chk("t1_second", dq[s+1], 32'h2);
    // partial write then read back
    setm(1, 0, 0, 0, 32'h0, 4'h0);
    setm(0, 1, 0, 5, 32'hDEADBEEF, 4'b0011);
    step();
    setm(0, 1, 0, 5, 32'h0, 4'h0);
    step();
    p = pre(5);
    chk("t2_rvalid", m0_rvalid, 32'h1);
    chk("t2_rdata", m0_rdata, {p[31:16], 16'hBEEF});
    setm(0, 0, 0, 0, 32'h0, 4'h0);
    step();
    // streaming reads alternate, m1 first since m0 was last
    s = dq.size();
    for (int k = 0; k < 6; k++) begin
      setm(0, 1, 0, $urandom % 32, 32'h0, 4'h0);
      setm(1, 1, 0, $urandom % 32, 32'h0, 4'h0);
      step();
    end
    for (int k = 0; k < 6; k++) chk("t3_alt", dq[s+k], k % 2 ? 32'h1 : 32'h2);
    // locked m0 holds MAX_HOLD extra grants then yields
    do_reset();
    s = dq.size();
    setm(0, 1, 1, 8, 32'h0, 4'h0);
    setm(1, 1, 0, 9, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) step();
    for (int k = 0; k < 5; k++) chk("t4_seq", dq[s+k], k < 4 ? 32'h1 : 32'h2);
    // reset right after a granted read drops the response
    setm(0, 0, 0, 0, 32'h0, 4'h0);
    setm(1, 1, 0, 7, 32'h0, 4'h0);
    step();
    chk("t5_pre", m1_rvalid, 32'h1);
    do_reset();
    // m0 withdraws while m1 owns the lock
    setm(0, 0, 0, 0, 32'h0, 4'h0);
    setm(1, 1, 1, 9, 32'h1234_5678, 4'hF);
    step();
    setm(0, 1, 0, 3, 32'h0, 4'h0);
    setm(1, 1, 1, 10, 32'h0, 4'h0);
    step();
    setm(0, 0, 0, 3, 32'h0, 4'h0);
    setm(1, 0, 0, 10, 32'h0, 4'h0);
    step();
    chk("t6_idle_we", ram_we, 32'h0);
    step();
    // random traffic with pending requests that may be withdrawn
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      for (int i = 0; i < 2; i++) begin
        if (!req_a[i] || gprev == i)
          setm(i, $urandom % 4 != 0, $urandom % 3 != 0, $urandom % 16, $urandom,
               $urandom % 2 ? 4'h0 : 4'($urandom));
        else if ($urandom % 8 == 0)
          req_a[i] = 1'b0;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
